// File: rtl/memory_bank_sdp.sv
// memory_bank_sdp: simple-dual-port RAM with byte enables, read pipeline, write-first bypass and init/clear sequencer
// Ports: Clk/Reset (async, active-high); Clear zeroes the array via INIT; Busy high during INIT.
//   Write port: WrValid/WrReady, WrAddr, WrData, WrByteEn (one bit per byte).
//   Read port:  RdValid/RdReady, RdAddr; RdDataValid strobes RdData ReadLatency cycles after accept.
module memory_bank_sdp #(
  parameter int AddrSize    = 8,
  parameter int DataSize    = 32,
  parameter int ReadLatency = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Clear,
  input  logic                    WrValid,
  output logic                    WrReady,
  input  logic [AddrSize-1:0]     WrAddr,
  input  logic [DataSize-1:0]     WrData,
  input  logic [DataSize/8-1:0]   WrByteEn,
  input  logic                    RdValid,
  output logic                    RdReady,
  input  logic [AddrSize-1:0]     RdAddr,
  output logic                    RdDataValid,
  output logic [DataSize-1:0]     RdData,
  output logic                    Busy
);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [AddrSize:0] LAST = {1'b0, {AddrSize{1'b1}}};
  logic [0:0]            state;
  logic [AddrSize:0]     cnt;
  logic [DataSize-1:0]   mem [2**AddrSize];
  logic [ReadLatency-1:0] pv;
  logic [DataSize-1:0]   pd [ReadLatency];
  logic                  clr, wr_acc, rd_acc;
  logic [DataSize-1:0]   wr_w, rd_w;
  assign WrReady     = state == RUN;
  assign RdReady     = state == RUN;
  assign Busy        = state == INIT;
  assign clr         = (state == RUN) && Clear;
  // a Clear edge leaves RUN, so nothing presented with it takes effect
  assign wr_acc      = WrValid && WrReady && !Clear;
  assign rd_acc      = RdValid && RdReady && !Clear;
  assign RdDataValid = pv[ReadLatency-1];
  assign RdData      = pd[ReadLatency-1];
  // merged word to be written; also the write-first bypass value on an address match
  always_comb begin
    wr_w = mem[WrAddr];
    for (int i = 0; i < DataSize/8; i++)
      if (WrByteEn[i]) wr_w[8*i +: 8] = WrData[8*i +: 8];
  end
  assign rd_w = (wr_acc && WrAddr == RdAddr) ? wr_w : mem[RdAddr];
  always_ff @(posedge Clk) begin
    if (state == INIT) mem[cnt[AddrSize-1:0]] <= '0;
    else if (wr_acc) mem[WrAddr] <= wr_w;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt   <= cnt + 1'b1;
      state <= cnt == LAST ? RUN : INIT;
    end else if (Clear) begin
      state <= INIT;
      cnt   <= '0;
    end
  end
  // data stages only advance behind a valid bit, so RdData holds between strobes and across a flush
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pv <= '0;
      for (int k = 0; k < ReadLatency; k++) pd[k] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= rd_w;
      for (int k = 1; k < ReadLatency; k++) begin
        pv[k] <= pv[k-1] && !clr;
        if (pv[k-1] && !clr) pd[k] <= pd[k-1];
      end
    end
  end
endmodule

// File: tb/tb_memory_bank_sdp.sv
// tb_memory_bank_sdp: scoreboard bench for memory_bank_sdp (AddrSize=4, ReadLatency=3)
module tb_memory_bank_sdp;
  localparam int AW = 4;
  localparam int L  = 3;
  localparam int DEPTH = 16;
  logic Clk = 0, Reset = 1, Clear = 0, WrValid = 0, RdValid = 0;
  logic WrReady, RdReady, RdDataValid, Busy;
  logic [AW-1:0] WrAddr = '0, RdAddr = '0;
  logic [31:0] WrData = '0, RdData;
  logic [3:0] WrByteEn = '0;
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] hold;
  typedef struct {logic [31:0] d; int e;} exp_t;
  exp_t q[$];
  exp_t mx;
  memory_bank_sdp #(.AddrSize(AW), .DataSize(32), .ReadLatency(L)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear),
    .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData), .WrByteEn(WrByteEn),
    .RdValid(RdValid), .RdReady(RdReady), .RdAddr(RdAddr),
    .RdDataValid(RdDataValid), .RdData(RdData), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction
  always @(posedge Clk) begin
    #1;
    if (RdDataValid) begin
      if (q.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
      else begin
        mx = q.pop_front();
        chk("rd_data", RdData, mx.d);
        chk("rd_latency", cyc, mx.e + L - 1);
      end
    end
  end
  task automatic step(bit wv, logic [AW-1:0] wa, logic [31:0] wd, logic [3:0] be,
                      bit rv, logic [AW-1:0] ra, bit clr = 0);
    logic [31:0] ed;
    @(negedge Clk);
    WrValid = wv; WrAddr = wa; WrData = wd; WrByteEn = be;
    RdValid = rv; RdAddr = ra; Clear = clr;
    if (clr) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      ed = (wv && wa == ra) ? merge(ref_mem[ra], wd, be) : ref_mem[ra];
      if (rv) q.push_back('{d: ed, e: cyc + 1});
      if (wv) ref_mem[wa] = merge(ref_mem[wa], wd, be);
    end
  endtask
  task automatic idle(int n = 1);
    repeat (n) step(0, '0, '0, '0, 0, '0);
  endtask
  task automatic wait_init(string tag);
    int n = 0;
    chk({tag, "_ready_low"}, {30'd0, WrReady, RdReady}, 32'd0);
    while (Busy === 1'b1 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk(tag, n, 32'd16);
    chk({tag, "_ready_high"}, {30'd0, WrReady, RdReady}, 32'd3);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    #12;
    chk("rst_busy", {31'd0, Busy}, 32'd1);
    chk("rst_ready", {30'd0, WrReady, RdReady}, 32'd0);
    chk("rst_rdvalid", {31'd0, RdDataValid}, 32'd0);
    chk("rst_rddata", RdData, 32'd0);
    @(negedge Clk);
    Reset = 0;
    wait_init("init_len");
    step(0, '0, '0, '0, 1, 4'd5);
    idle(4);
    step(1, 4'd3, 32'hAABBCCDD, 4'b1111, 0, '0);
    step(1, 4'd3, 32'h11223344, 4'b0101, 0, '0);
    step(0, '0, '0, '0, 1, 4'd3);
    idle(4);
    chk("be_result", RdData, 32'hAA22CC44);
    step(1, 4'd7, 32'h0000FFFF, 4'b1111, 0, '0);
    step(1, 4'd7, 32'h12345678, 4'b1100, 1, 4'd7);
    idle(4);
    chk("collision_result", RdData, 32'h1234FFFF);
    step(1, 4'd1, 32'h01010101, 4'b1111, 0, '0);
    step(1, 4'd2, 32'h02020202, 4'b1111, 0, '0);
    step(0, '0, '0, '0, 1, 4'd1);
    step(0, '0, '0, '0, 1, 4'd2);
    step(0, '0, '0, '0, 1, 4'd3);
    idle(5);
    step(1, 4'd9, 32'hDEADBEEF, 4'b0000, 1, 4'd9);
    idle(4);
    repeat (40)
      step(bit'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom),
           bit'($urandom_range(0, 1)), AW'($urandom));
    idle(6);
    chk("pending_pre_clear", q.size(), 32'd0);
    hold = RdData;
    step(0, '0, '0, '0, 1, 4'd3);
    void'(q.pop_back());
    step(0, '0, '0, '0, 0, '0, 1);
    idle();
    chk("clear_busy", {31'd0, Busy}, 32'd1);
    wait_init("clear_len");
    chk("clear_rd_hold", RdData, hold);
    for (int i = 0; i < DEPTH; i++) step(0, '0, '0, '0, 1, AW'(i));
    idle(6);
    chk("pending_post_clear", q.size(), 32'd0);
    step(1, 4'd4, 32'hCAFEF00D, 4'b1111, 0, '0);
    step(0, '0, '0, '0, 0, '0, 1);
    idle(8);
    Reset = 1;
    #1;
    chk("midinit_rst_busy", {31'd0, Busy}, 32'd1);
    chk("midinit_rst_rddata", RdData, 32'd0);
    foreach (ref_mem[i]) ref_mem[i] = '0;
    @(negedge Clk);
    Reset = 0;
    wait_init("reinit_len");
    step(0, '0, '0, '0, 1, 4'd4);
    step(0, '0, '0, '0, 1, 4'd7);
    idle(6);
    chk("pending_end", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
